// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI byte-engine controller.
//   state_e  : controller FSM states
//   BYTE_CYC : engine clock cycles per byte
//   PHASE_W  : width of the per-byte phase counter
package spi_ctrl_pkg;

  localparam int BYTE_CYC = 16;
  localparam int PHASE_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE,
    ST_FIN,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   req    : request level per requester
//   rr_ptr : requester that wins when both request
//   sel    : one-hot winner, zero when nobody requests
module spi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] sel
);

  always_comb begin
    sel = req;
    if (req == 2'b11) begin
      sel = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Two-requester round-robin controller for the SPI byte engine.
// Grants one requester at a time, runs its write bytes then its read bytes
// through the engine with 16-cycle byte framing, and returns read data.
//   clk, rst       : clock, synchronous active-high reset
//   req            : per-requester request level, held until done
//   wr_len, rd_len : per-requester byte counts (requester 0 in low field)
//   wr_data        : per-requester next write byte (requester 0 in [7:0])
//   gnt            : one-hot grant for the whole transaction
//   wr_pop         : pulse, current wr_data byte consumed
//   rd_data        : shared read byte, qualified by rd_valid
//   rd_valid       : pulse per read byte for the granted requester
//   done           : pulse at transaction end
//   eng_tx_en/rx_en: engine enables (never high together)
//   eng_data_in    : byte driven to the engine
//   eng_data_out   : byte received by the engine
//   eng_rx_done    : engine receive-byte-complete flag
import spi_ctrl_pkg::*;

module spi_master_arbiter #(
  parameter int LEN_W = 4,
  parameter int GAP   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] wr_len,
  input  logic [2*LEN_W-1:0] rd_len,
  input  logic [15:0]        wr_data,
  output logic [1:0]         gnt,
  output logic [1:0]         wr_pop,
  output logic [7:0]         rd_data,
  output logic [1:0]         rd_valid,
  output logic [1:0]         done,
  output logic               eng_tx_en,
  output logic               eng_rx_en,
  output logic [7:0]         eng_data_in,
  input  logic [7:0]         eng_data_out,
  input  logic               eng_rx_done
);

  localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         wr_pop_q, wr_pop_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic [1:0]         rd_valid_q, rd_valid_d;
  logic [1:0]         done_q, done_d;
  logic               tx_en_q, tx_en_d;
  logic               rx_en_q, rx_en_d;
  logic [7:0]         data_in_q, data_in_d;
  logic [LEN_W-1:0]   wr_len_q, wr_len_d;
  logic [LEN_W-1:0]   rd_len_q, rd_len_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [LEN_W-1:0]   byte_q, byte_d;
  logic [GAP_CW-1:0]  gap_q, gap_d;
  logic               rr_ptr_q, rr_ptr_d;

  logic [1:0]       arb_sel;
  logic [LEN_W-1:0] sel_wr_len, sel_rd_len;
  logic [7:0]       sel_wr_data, gnt_wr_data;
  logic             phase_last;

  spi_rr_arb2 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .sel    (arb_sel)
  );

  assign sel_wr_len  = arb_sel[1] ? wr_len[2*LEN_W-1:LEN_W] : wr_len[LEN_W-1:0];
  assign sel_rd_len  = arb_sel[1] ? rd_len[2*LEN_W-1:LEN_W] : rd_len[LEN_W-1:0];
  assign sel_wr_data = arb_sel[1] ? wr_data[15:8] : wr_data[7:0];
  assign gnt_wr_data = gnt_q[1]   ? wr_data[15:8] : wr_data[7:0];
  assign phase_last  = (phase_q == PHASE_W'(BYTE_CYC - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    wr_pop_d   = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    done_d     = '0;
    tx_en_d    = tx_en_q;
    rx_en_d    = rx_en_q;
    data_in_d  = data_in_q;
    wr_len_d   = wr_len_q;
    rd_len_d   = rd_len_q;
    phase_d    = phase_q;
    byte_d     = byte_q;
    gap_d      = gap_q;
    rr_ptr_d   = rr_ptr_q;

    // The last receive flag lands one cycle after the read window closes,
    // which is why CAPTURE still accepts it.
    if ((state_q == ST_READ || state_q == ST_CAPTURE) && eng_rx_done) begin
      rd_data_d  = eng_data_out;
      rd_valid_d = gnt_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d    = arb_sel;
          wr_len_d = sel_wr_len;
          rd_len_d = sel_rd_len;
          phase_d  = '0;
          byte_d   = '0;
          if (sel_wr_len != '0) begin
            tx_en_d   = 1'b1;
            data_in_d = sel_wr_data;
            wr_pop_d  = arb_sel;
            state_d   = ST_WRITE;
          end else if (sel_rd_len != '0) begin
            rx_en_d = 1'b1;
            state_d = ST_READ;
          end else begin
            done_d  = arb_sel;
            state_d = ST_FIN;
          end
        end
      end

      ST_WRITE: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_last) begin
          if (byte_q == wr_len_q - LEN_W'(1)) begin
            tx_en_d = 1'b0;
            byte_d  = '0;
            if (rd_len_q != '0) begin
              rx_en_d = 1'b1;
              state_d = ST_READ;
            end else begin
              done_d  = gnt_q;
              state_d = ST_FIN;
            end
          end else begin
            // Next byte is loaded so it is stable from its phase 0.
            byte_d    = byte_q + LEN_W'(1);
            data_in_d = gnt_wr_data;
            wr_pop_d  = gnt_q;
          end
        end
      end

      ST_READ: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_last) begin
          if (byte_q == rd_len_q - LEN_W'(1)) begin
            rx_en_d = 1'b0;
            state_d = ST_CAPTURE;
          end else begin
            byte_d = byte_q + LEN_W'(1);
          end
        end
      end

      ST_CAPTURE: begin
        done_d  = gnt_q;
        state_d = ST_FIN;
      end

      ST_FIN: begin
        gnt_d    = '0;
        rr_ptr_d = gnt_q[0];
        gap_d    = '0;
        state_d  = (GAP == 0) ? ST_IDLE : ST_GAP;
      end

      ST_GAP: begin
        gap_d = gap_q + GAP_CW'(1);
        if (gap_q == GAP_CW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      wr_pop_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      done_q     <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      data_in_q  <= '0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      phase_q    <= '0;
      byte_q     <= '0;
      gap_q      <= '0;
      rr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      wr_pop_q   <= wr_pop_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      tx_en_q    <= tx_en_d;
      rx_en_q    <= rx_en_d;
      data_in_q  <= data_in_d;
      wr_len_q   <= wr_len_d;
      rd_len_q   <= rd_len_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
      gap_q      <= gap_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign gnt         = gnt_q;
  assign wr_pop      = wr_pop_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign eng_tx_en   = tx_en_q;
  assign eng_rx_en   = rx_en_q;
  assign eng_data_in = data_in_q;

endmodule
